// File: rtl/eprisc_iobus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eprisc_iobus_master
// Purpose  : CPU-side epRISC I/O bus master; builds 7-phase bus frames from
//            single requests, resets the controller and syncs its interrupt.
// Revision : 1.0  initial release
// ============================================================================
module eprisc_iobus_master #(
    parameter int unsigned CLK_DIV      = 4,
    parameter logic [1:0]  SELECT       = 2'b01,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oRspValid,
    output logic [15:0] oRspData,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt,
    output logic        oIrq
);

    localparam int unsigned C_HALF_W  = $clog2(CLK_DIV);
    localparam int unsigned C_RST_LEN = RESET_CYCLES * 2 * CLK_DIV;
    localparam int unsigned C_RST_W   = $clog2(C_RST_LEN + 1);
    localparam logic [C_HALF_W-1:0] C_HALF_MAX = C_HALF_W'(CLK_DIV - 1);
    localparam logic [C_RST_W-1:0]  C_RST_MAX  = C_RST_W'(C_RST_LEN - 1);
    localparam logic [2:0]          C_LAST_PH  = 3'd6;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_FRAME = 2'd2,
        S_FETCH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [C_HALF_W-1:0]   half_q, half_d;
    logic [2:0]            phase_q, phase_d;
    logic [C_RST_W-1:0]    rcnt_q, rcnt_d;
    logic [31:0]           word_q, word_d;
    logic                  bclk_q, bclk_d;
    logic [1:0]            sel_q, sel_d;
    logic [7:0]            mosi_q, mosi_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [15:0]           rsp_data_q, rsp_data_d;
    logic [15:0]           rd_q, rd_d;
    logic                  irq_meta_q, irq_q;

    logic                  w_tick;
    logic                  w_accept;
    logic [7:0]            w_frame_byte;

    assign oReqReady  = (state_q == S_IDLE) && !rsp_valid_q;
    assign w_accept   = iReqValid && oReqReady;
    assign w_tick     = (half_q == C_HALF_MAX);
    assign oRspValid  = rsp_valid_q;
    assign oRspData   = rsp_data_q;
    assign oBusClock  = bclk_q;
    assign oBusSelect = sel_q;
    assign oBusMOSI   = mosi_q;
    assign oIrq       = irq_q;

    // Byte for the phase the controller enters on the coming rising edge.
    always_comb begin
        w_frame_byte = 8'h00;
        case (phase_q)
            3'd1:    w_frame_byte = word_q[7:0];
            3'd2:    w_frame_byte = word_q[15:8];
            3'd3:    w_frame_byte = word_q[23:16];
            3'd4:    w_frame_byte = word_q[31:24];
            default: w_frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        phase_d     = phase_q;
        rcnt_d      = rcnt_q;
        word_d      = word_q;
        bclk_d      = bclk_q;
        sel_d       = sel_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rd_d        = rd_q;
        case (state_q)
            S_RESET: begin
                sel_d  = 2'b00;
                bclk_d = 1'b0;
                if (rcnt_q == C_RST_MAX) begin
                    sel_d   = SELECT;
                    state_d = S_IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    word_d  = {iReqWrite, iReqAddr, iReqData};
                    half_d  = '0;
                    phase_d = 3'd0;
                    state_d = S_FRAME;
                end
            end
            default: begin
                half_d = half_q + 1'b1;
                if (w_tick) begin
                    half_d = '0;
                    bclk_d = ~bclk_q;
                    if (!bclk_q) begin
                        mosi_d = w_frame_byte;
                    end else begin
                        // Read data for the previous frame arrives in LOLO/LO of the fetch frame.
                        if (state_q == S_FETCH && phase_q == 3'd1) rd_d[7:0]  = iBusMISO;
                        if (state_q == S_FETCH && phase_q == 3'd2) rd_d[15:8] = iBusMISO;
                        if (phase_q == C_LAST_PH) begin
                            phase_d = 3'd0;
                            if (state_q == S_FRAME && !word_q[31]) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d     = S_IDLE;
                                rsp_valid_d = 1'b1;
                                if (state_q == S_FETCH) rsp_data_d = rd_q;
                            end
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= S_RESET;
            half_q      <= '0;
            phase_q     <= 3'd0;
            rcnt_q      <= '0;
            word_q      <= 32'h0;
            bclk_q      <= 1'b0;
            sel_q       <= 2'b00;
            mosi_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0;
            rd_q        <= 16'h0;
            irq_meta_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            phase_q     <= phase_d;
            rcnt_q      <= rcnt_d;
            word_q      <= word_d;
            bclk_q      <= bclk_d;
            sel_q       <= sel_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rd_q        <= rd_d;
            irq_meta_q  <= iBusInterrupt;
            irq_q       <= irq_meta_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eprisc_iobus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eprisc_iobus_master
// Purpose  : Self-checking bench with a behavioural I/O controller + RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_eprisc_iobus_master;

    localparam int         D   = 4;
    localparam int         RC  = 4;
    localparam logic [1:0] SEL = 2'b01;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [14:0] iReqAddr;
    logic [15:0] iReqData;
    logic        oRspValid;
    logic [15:0] oRspData;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO;
    logic        iBusInterrupt;
    logic        oIrq;

    eprisc_iobus_master #(
        .CLK_DIV      (D),
        .SELECT       (SEL),
        .RESET_CYCLES (RC)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iReqValid     (iReqValid),
        .oReqReady     (oReqReady),
        .iReqWrite     (iReqWrite),
        .iReqAddr      (iReqAddr),
        .iReqData      (iReqData),
        .oRspValid     (oRspValid),
        .oRspData      (oRspData),
        .oBusClock     (oBusClock),
        .oBusSelect    (oBusSelect),
        .oBusMOSI      (oBusMOSI),
        .iBusMISO      (iBusMISO),
        .iBusInterrupt (iBusInterrupt),
        .oIrq          (oIrq)
    );

    always #5 iClk = ~iClk;

    int cyc;
    always @(posedge iClk) cyc <= cyc + 1;

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural I/O controller: collects one byte per bus rising edge,
    // acts on the word at STORE, and presents the last read in LOLO/LO.
    // ------------------------------------------------------------------
    logic [15:0] cram [32768];
    logic [7:0]  cfr [7];
    logic [2:0]  ccnt;
    logic [2:0]  ccur;
    logic [15:0] crd;
    logic        cbclk;

    always @(posedge iClk) begin
        cbclk <= oBusClock;
        if (oBusSelect == 2'b00) begin
            ccnt <= 3'd0;
            ccur <= 3'd0;
        end else if (oBusClock && !cbclk) begin
            cfr[ccnt] <= oBusMOSI;
            ccur      <= ccnt;
            ccnt      <= (ccnt == 3'd6) ? 3'd0 : ccnt + 3'd1;
            if (ccnt == 3'd6) begin
                if (cfr[4][7]) cram[{cfr[4][6:0], cfr[3]}] <= {cfr[2], cfr[1]};
                else           crd <= cram[{cfr[4][6:0], cfr[3]}];
            end
        end
    end

    assign iBusMISO = (ccur == 3'd1) ? crd[7:0] : (ccur == 3'd2) ? crd[15:8] : 8'h00;

    // ------------------------------------------------------------------
    // Reference model and scoreboard, sampled on the falling iClk edge.
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] mram [32768];
    int          t0;
    int          ek;
    int          acc_cnt;
    bit          act;
    bit          pbclk;
    logic [31:0] mw;

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
        int          p;
        logic [31:0] fw;
        p  = k % 7;
        fw = (k >= 7) ? {1'b0, w[30:0]} : w;
        return (p >= 1 && p <= 4) ? fw[8*(p-1) +: 8] : 8'h00;
    endfunction

    always @(negedge iClk) begin
        exp_t e;
        if (oBusClock && !pbclk) begin
            check("bus edge inside frame", 32'(act), 32'd1);
            check("bus rise time", 32'(cyc - t0), 32'(D * (2 * ek + 1)));
            check("mosi byte", 32'(oBusMOSI), 32'(exp_byte(mw, ek)));
            ek++;
        end
        if (oRspValid) begin
            if (expq.size() == 0) begin
                check("rsp without request", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                check("rsp cycle", 32'(cyc), 32'(e.due));
                if (e.rd) check("rsp data", 32'(oRspData), 32'(e.data));
                check("bus edges per txn", 32'(ek), e.rd ? 32'd14 : 32'd7);
            end
            act = 1'b0;
        end else if (expq.size() > 0 && cyc > expq[0].due) begin
            check("rsp timeout", 32'(cyc), 32'(expq[0].due));
            void'(expq.pop_front());
            act = 1'b0;
        end
        if (iRst) begin
            expq.delete();
            act = 1'b0;
        end else if (iReqValid && oReqReady) begin
            acc_cnt++;
            if (iReqWrite) mram[iReqAddr] = iReqData;
            e.due  = cyc + 1 + (iReqWrite ? 14 : 28) * D;
            e.rd   = !iReqWrite;
            e.data = mram[iReqAddr];
            expq.push_back(e);
            t0  = cyc + 1;
            ek  = 0;
            act = 1'b1;
            mw  = {iReqWrite, iReqAddr, iReqData};
        end
        pbclk = oBusClock;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!oReqReady && n < 400) begin
            @(posedge iClk); #1;
            n++;
        end
        check("ready wait", 32'(oReqReady), 32'd1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!oRspValid && n < 200) begin
            @(posedge iClk); #1;
            n++;
        end
        check("rsp wait", 32'(oRspValid), 32'd1);
    endtask

    task automatic do_req(input logic wr, input logic [14:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        int t_acc;
        iReqValid = 1'b1;
        iReqWrite = wr;
        iReqAddr  = a;
        iReqData  = d;
        wait_ready();
        @(posedge iClk); #1;
        t_acc     = cyc;
        iReqValid = 1'b0;
        iReqWrite = 1'($urandom);
        iReqAddr  = 15'($urandom);
        iReqData  = 16'($urandom);
        wait_rsp();
        lat = oRspValid ? cyc - t_acc : -1;
        rd  = oRspData;
    endtask

    task automatic wait_select(output int n, output bit clk_seen);
        n        = 0;
        clk_seen = 1'b0;
        do begin
            @(posedge iClk); #1;
            n++;
            clk_seen |= oBusClock;
        end while (oBusSelect == 2'b00 && n < 100);
    endtask

    typedef struct {
        logic        wr;
        logic [14:0] a;
        logic [15:0] d;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t        tbl [10];
    logic [14:0] pool [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [15:0] rd;
        int          lat;
        int          n;
        int          t_acc;
        int          r;
        int          a0;
        bit          seen;
        logic        wr;

        tbl[0] = '{1'b1, 15'h0045, 16'hBEEF, 16'h0000, 14 * D};
        tbl[1] = '{1'b0, 15'h0045, 16'h0000, 16'hBEEF, 28 * D};
        tbl[2] = '{1'b1, 15'h0000, 16'h0001, 16'h0000, 14 * D};
        tbl[3] = '{1'b1, 15'h7FFE, 16'hFFFF, 16'h0000, 14 * D};
        tbl[4] = '{1'b0, 15'h0000, 16'h1234, 16'h0001, 28 * D};
        tbl[5] = '{1'b0, 15'h7FFE, 16'h0000, 16'hFFFF, 28 * D};
        tbl[6] = '{1'b1, 15'h2A55, 16'h5AA5, 16'h0000, 14 * D};
        tbl[7] = '{1'b0, 15'h2A55, 16'hFFFF, 16'h5AA5, 28 * D};
        tbl[8] = '{1'b1, 15'h0100, 16'hC3C3, 16'h0000, 14 * D};
        tbl[9] = '{1'b0, 15'h0100, 16'h0000, 16'hC3C3, 28 * D};

        iRst          = 1'b1;
        iReqValid     = 1'b0;
        iReqWrite     = 1'b0;
        iReqAddr      = 15'h0;
        iReqData      = 16'h0;
        iBusInterrupt = 1'b0;

        // Reset values and controller-reset hold time
        repeat (3) @(posedge iClk);
        #1;
        check("reset ready", 32'(oReqReady), 32'd0);
        check("reset rsp valid", 32'(oRspValid), 32'd0);
        check("reset rsp data", 32'(oRspData), 32'd0);
        check("reset bus clock", 32'(oBusClock), 32'd0);
        check("reset select", 32'(oBusSelect), 32'd0);
        check("reset mosi", 32'(oBusMOSI), 32'd0);
        check("reset irq", 32'(oIrq), 32'd0);
        iRst = 1'b0;
        wait_select(n, seen);
        check("select hold cycles", 32'(n), 32'(RC * 2 * D));
        check("clock low in reset", 32'(seen), 32'd0);
        check("select after reset", 32'(oBusSelect), 32'(SEL));
        check("ready after reset", 32'(oReqReady), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i].wr, tbl[i].a, tbl[i].d, rd, lat);
            check("table latency", 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].wr) check("table ctrl ram", 32'(cram[tbl[i].a]), 32'(tbl[i].d));
            else           check("table read data", 32'(rd), 32'(tbl[i].exp));
        end

        // Request held valid across a write
        a0        = acc_cnt;
        iReqValid = 1'b1;
        iReqWrite = 1'b1;
        iReqAddr  = 15'h0046;
        iReqData  = 16'h1357;
        wait_ready();
        @(posedge iClk); #1;
        t_acc = cyc;
        wait_rsp();
        r = cyc;
        check("held write latency", 32'(r - t_acc), 32'(14 * D));
        check("held accepts first", 32'(acc_cnt - a0), 32'd1);
        @(posedge iClk); #1;
        check("ready after rsp", 32'(oReqReady), 32'd1);
        @(posedge iClk); #1;
        check("held accepts second", 32'(acc_cnt - a0), 32'd2);
        check("ready drops on accept", 32'(oReqReady), 32'd0);
        iReqValid = 1'b0;
        wait_rsp();
        check("held second latency", 32'(cyc - r), 32'(2 + 14 * D));

        // Reset during the HI phase of a read
        @(posedge iClk); #1;
        iReqValid = 1'b1;
        iReqWrite = 1'b0;
        iReqAddr  = 15'h0045;
        wait_ready();
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        repeat (7 * D + 1) @(posedge iClk);
        #1;
        check("in HI phase clock", 32'(oBusClock), 32'd1);
        iRst = 1'b1;
        @(posedge iClk); #1;
        check("abort clock", 32'(oBusClock), 32'd0);
        check("abort select", 32'(oBusSelect), 32'd0);
        check("abort rsp", 32'(oRspValid), 32'd0);
        iRst = 1'b0;
        wait_select(n, seen);
        check("abort select hold", 32'(n), 32'(RC * 2 * D));
        do_req(1'b0, 15'h0045, 16'h0000, rd, lat);
        check("recovery latency", 32'(lat), 32'(28 * D));
        check("recovery read data", 32'(rd), 32'hBEEF);

        // Interrupt synchroniser
        iBusInterrupt = 1'b1;
        @(posedge iClk); #1;
        check("irq rise +1", 32'(oIrq), 32'd0);
        @(posedge iClk); #1;
        check("irq rise +2", 32'(oIrq), 32'd1);
        iBusInterrupt = 1'b0;
        @(posedge iClk); #1;
        check("irq fall +1", 32'(oIrq), 32'd1);
        @(posedge iClk); #1;
        check("irq fall +2", 32'(oIrq), 32'd0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 8; i++) begin
            pool[i] = 15'($urandom_range(0, 32766));
            do_req(1'b1, pool[i], 16'($urandom), rd, lat);
        end
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom);
            do_req(wr, pool[$urandom_range(0, 7)], 16'($urandom), rd, lat);
            check("random latency", 32'(lat), wr ? 32'(14 * D) : 32'(28 * D));
            repeat ($urandom_range(0, 3)) begin
                @(posedge iClk); #1;
            end
        end

        repeat (4) @(posedge iClk);
        #1;
        check("no pending rsp", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
